unidade_busca: RTL and testbench

Instruction-fetch stage directly upstream of the `memoria` block in the 16-bit core.
- Drives the memory address from its program counter (PC).
- Captures the combinationally-read word at the next clock edge.
- Queues up to `profundidade` instructions, each with its PC, for the decode stage over a valid/ready handshake.
- Yields the memory port when the load/store path owns it, and redirects on branches/jumps.

---
 rtl/busca_pkg.sv | 10 +
 rtl/fila_busca.sv | 51 +++++
 rtl/unidade_busca.sv | 62 ++++++
 tb/tb_unidade_busca.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/busca_pkg.sv
// busca_pkg: shared types and default widths for the instruction-fetch stage
package busca_pkg;
   localparam int BITS    = 16;
   localparam int TAMANHO = 8;
   typedef enum logic [1:0] {INICIO, BUSCANDO, REDIRECIONANDO} estado_busca_t;
   typedef struct packed {
      logic [BITS-1:0]    instr;
      logic [TAMANHO-1:0] pc;
   } entrada_busca_t;
endpackage

// File: rtl/fila_busca.sv
// fila_busca: circular FIFO of fetched {instr, pc} entries with flush
module fila_busca
   import busca_pkg::*;
#(
   parameter int profundidade = 2
) (
   input  logic                                clock,
   input  logic                                reset_n,
   input  logic                                push,
   input  logic                                pop,
   input  logic                                flush,
   input  entrada_busca_t                      din,
   output entrada_busca_t                      dout,
   output logic [$clog2(profundidade+1)-1:0]   count,
   output logic                                full,
   output logic                                empty
);
   localparam int CW = $clog2(profundidade+1);
   localparam int PW = (profundidade > 1) ? $clog2(profundidade) : 1;
   entrada_busca_t mem_q [profundidade];
   entrada_busca_t mem_d [profundidade];
   logic [PW-1:0] head_q, head_d, tail_q, tail_d;
   logic [CW-1:0] count_q, count_d;
   function automatic logic [PW-1:0] avanca(input logic [PW-1:0] p);
      return (p == PW'(profundidade-1)) ? '0 : p + 1'b1;
   endfunction
   always_comb begin
      mem_d = mem_q;
      if (push && !flush) mem_d[tail_q] = din;
      head_d  = flush ? '0 : pop  ? avanca(head_q) : head_q;
      tail_d  = flush ? '0 : push ? avanca(tail_q) : tail_q;
      count_d = flush ? '0 : (push && !pop) ? count_q + 1'b1 : (pop && !push) ? count_q - 1'b1 : count_q;
   end
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         mem_q   <= '{default: '0};
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         mem_q   <= mem_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end
   assign dout  = mem_q[head_q];
   assign count = count_q;
   assign full  = count_q == CW'(profundidade);
   assign empty = count_q == '0;
endmodule

// File: rtl/unidade_busca.sv
// unidade_busca: PC, fetch FSM and handshake logic feeding decode from memoria
module unidade_busca
   import busca_pkg::*;
#(
   parameter int bits         = BITS,
   parameter int tamanho      = TAMANHO,
   parameter int profundidade = 2,
   parameter int end_reset    = 0
) (
   input  logic            clock,
   input  logic            reset_n,
   output logic [bits-1:0] mem_endereco,
   input  logic [bits-1:0] mem_dado,
   input  logic            mem_livre,
   input  logic            desvio,
   input  logic [bits-1:0] alvo,
   output logic [bits-1:0] instr,
   output logic [bits-1:0] pc_instr,
   output logic            instr_valida,
   input  logic            instr_pronta
);
   localparam int CW = $clog2(profundidade+1);
   estado_busca_t  state_q, state_d;
   logic [tamanho-1:0] pc_q, pc_d;
   entrada_busca_t entrada, cabeca;
   logic push, pop, full, empty;
   logic [CW-1:0] count;
   always_comb begin
      pop           = !empty && instr_pronta;
      push          = (state_q == BUSCANDO) && mem_livre && !desvio && (!full || pop);
      state_d       = desvio ? REDIRECIONANDO : BUSCANDO;
      pc_d          = desvio ? tamanho'(alvo) : push ? pc_q + 1'b1 : pc_q;
      entrada.instr = BITS'(mem_dado);
      entrada.pc    = TAMANHO'(pc_q);
   end
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= INICIO;
         pc_q    <= tamanho'(end_reset);
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
      end
   end
   fila_busca #(.profundidade(profundidade)) u_fila (
      .clock   (clock),
      .reset_n (reset_n),
      .push    (push),
      .pop     (pop),
      .flush   (desvio),
      .din     (entrada),
      .dout    (cabeca),
      .count   (count),
      .full    (full),
      .empty   (empty)
   );
   assert property (@(posedge clock) disable iff (!reset_n) count <= CW'(profundidade));
   assign mem_endereco = bits'(pc_q);
   assign instr        = bits'(cabeca.instr);
   assign pc_instr     = bits'(cabeca.pc);
   assign instr_valida = !empty;
endmodule

// File: tb/tb_unidade_busca.sv
// tb_unidade_busca: directed scenario checks for the fetch stage against a 256-word memory model
module tb_unidade_busca;
   logic        clock = 0;
   logic        reset_n = 0;
   logic [15:0] mem_endereco, mem_dado, alvo, instr, pc_instr;
   logic        mem_livre = 1, desvio = 0, instr_valida, instr_pronta = 1;
   logic [15:0] memoria [256];
   int errors = 0, checks = 0;

   always #5 clock = ~clock;
   assign mem_dado = memoria[mem_endereco[7:0]];

   unidade_busca dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .mem_endereco (mem_endereco),
      .mem_dado     (mem_dado),
      .mem_livre    (mem_livre),
      .desvio       (desvio),
      .alvo         (alvo),
      .instr        (instr),
      .pc_instr     (pc_instr),
      .instr_valida (instr_valida),
      .instr_pronta (instr_pronta)
   );

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset;
      reset_n = 0;
      #2;
      checks++; if (instr_valida !== 1'b0) begin errors++; $display("FAIL rst_valida: got %b expected 0", instr_valida); end
      checks++; if (instr !== 16'h0000) begin errors++; $display("FAIL rst_instr: got %h expected 0000", instr); end
      checks++; if (pc_instr !== 16'h0000) begin errors++; $display("FAIL rst_pc_instr: got %h expected 0000", pc_instr); end
      checks++; if (mem_endereco !== 16'h0000) begin errors++; $display("FAIL rst_endereco: got %h expected 0000", mem_endereco); end
      tick;
      reset_n = 1;
   endtask

   task automatic test_fetch;
      tick;
      checks++; if (instr_valida !== 1'b0) begin errors++; $display("FAIL bubble_valida: got %b expected 0", instr_valida); end
      for (int i = 0; i < 3; i++) begin
         tick;
         checks++; if (instr_valida !== 1'b1) begin errors++; $display("FAIL fetch_valida[%0d]: got %b expected 1", i, instr_valida); end
         checks++; if (instr !== 16'hA000 + 16'(i)) begin errors++; $display("FAIL fetch_instr[%0d]: got %h expected %h", i, instr, 16'hA000 + 16'(i)); end
         checks++; if (pc_instr !== 16'(i)) begin errors++; $display("FAIL fetch_pc[%0d]: got %h expected %h", i, pc_instr, 16'(i)); end
      end
   endtask

   task automatic test_stall;
      instr_pronta = 0;
      reset_n = 0;
      tick;
      tick;
      reset_n = 1;
      repeat (7) tick;
      checks++; if (instr !== 16'hA000 || pc_instr !== 16'h0000 || instr_valida !== 1'b1) begin errors++; $display("FAIL stall_head: got %h/%h/%b expected A000/0000/1", instr, pc_instr, instr_valida); end
      checks++; if (mem_endereco !== 16'h0002) begin errors++; $display("FAIL stall_endereco: got %h expected 0002", mem_endereco); end
   endtask

   task automatic test_full_pop;
      instr_pronta = 1;
      tick;
      instr_pronta = 0;
      checks++; if (instr !== 16'hA001 || pc_instr !== 16'h0001) begin errors++; $display("FAIL fullpop_head: got %h/%h expected A001/0001", instr, pc_instr); end
      checks++; if (mem_endereco !== 16'h0003) begin errors++; $display("FAIL fullpop_endereco: got %h expected 0003", mem_endereco); end
      tick;
      checks++; if (instr !== 16'hA001 || mem_endereco !== 16'h0003) begin errors++; $display("FAIL full_hold: got %h/%h expected A001/0003", instr, mem_endereco); end
      instr_pronta = 1;
      tick;
      checks++; if (instr !== 16'hA002 || pc_instr !== 16'h0002 || mem_endereco !== 16'h0004) begin errors++; $display("FAIL fullpop_next: got %h/%h/%h expected A002/0002/0004", instr, pc_instr, mem_endereco); end
      tick;
      checks++; if (instr !== 16'hA003 || pc_instr !== 16'h0003 || mem_endereco !== 16'h0005) begin errors++; $display("FAIL fullpop_next2: got %h/%h/%h expected A003/0003/0005", instr, pc_instr, mem_endereco); end
   endtask

   task automatic test_desvio;
      desvio = 1;
      alvo = 16'h1234;
      tick;
      desvio = 0;
      alvo = 16'h0000;
      checks++; if (instr_valida !== 1'b0) begin errors++; $display("FAIL desvio_flush: got %b expected 0", instr_valida); end
      checks++; if (mem_endereco !== 16'h0034) begin errors++; $display("FAIL desvio_endereco: got %h expected 0034", mem_endereco); end
      tick;
      checks++; if (instr_valida !== 1'b0) begin errors++; $display("FAIL desvio_bubble: got %b expected 0", instr_valida); end
      tick;
      checks++; if (instr_valida !== 1'b1 || instr !== 16'hA034 || pc_instr !== 16'h0034) begin errors++; $display("FAIL desvio_first: got %b/%h/%h expected 1/A034/0034", instr_valida, instr, pc_instr); end
   endtask

   task automatic test_wrap;
      desvio = 1;
      alvo = 16'hABFF;
      tick;
      desvio = 0;
      checks++; if (mem_endereco !== 16'h00FF) begin errors++; $display("FAIL wrap_endereco: got %h expected 00FF", mem_endereco); end
      tick;
      tick;
      checks++; if (instr !== 16'hA0FF || pc_instr !== 16'h00FF) begin errors++; $display("FAIL wrap_last: got %h/%h expected A0FF/00FF", instr, pc_instr); end
      checks++; if (mem_endereco !== 16'h0000) begin errors++; $display("FAIL wrap_pc: got %h expected 0000", mem_endereco); end
      tick;
      checks++; if (instr !== 16'hA000 || pc_instr !== 16'h0000 || mem_endereco !== 16'h0001) begin errors++; $display("FAIL wrap_first: got %h/%h/%h expected A000/0000/0001", instr, pc_instr, mem_endereco); end
   endtask

   task automatic test_mem_livre;
      mem_livre = 0;
      tick;
      checks++; if (instr_valida !== 1'b0 || mem_endereco !== 16'h0001) begin errors++; $display("FAIL livre_drain: got %b/%h expected 0/0001", instr_valida, mem_endereco); end
      tick;
      tick;
      checks++; if (instr_valida !== 1'b0 || mem_endereco !== 16'h0001) begin errors++; $display("FAIL livre_hold: got %b/%h expected 0/0001", instr_valida, mem_endereco); end
      mem_livre = 1;
      tick;
      checks++; if (instr_valida !== 1'b1 || instr !== 16'hA001 || pc_instr !== 16'h0001 || mem_endereco !== 16'h0002) begin errors++; $display("FAIL livre_resume: got %b/%h/%h/%h expected 1/A001/0001/0002", instr_valida, instr, pc_instr, mem_endereco); end
   endtask

   task automatic test_reset_mid;
      instr_pronta = 0;
      tick;
      #3;
      reset_n = 0;
      #1;
      checks++; if (instr_valida !== 1'b0 || instr !== 16'h0000 || pc_instr !== 16'h0000) begin errors++; $display("FAIL async_rst_out: got %b/%h/%h expected 0/0000/0000", instr_valida, instr, pc_instr); end
      checks++; if (mem_endereco !== 16'h0000) begin errors++; $display("FAIL async_rst_pc: got %h expected 0000", mem_endereco); end
      tick;
      reset_n = 1;
      tick;
      checks++; if (instr_valida !== 1'b0) begin errors++; $display("FAIL restart_bubble: got %b expected 0", instr_valida); end
      tick;
      checks++; if (instr_valida !== 1'b1 || instr !== 16'hA000 || pc_instr !== 16'h0000) begin errors++; $display("FAIL restart_first: got %b/%h/%h expected 1/A000/0000", instr_valida, instr, pc_instr); end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not end, time %0t", $time);
      $fatal(1);
   end

   initial begin
      alvo = 16'h0000;
      for (int i = 0; i < 256; i++) memoria[i] = 16'hA000 | 16'(i);
      test_reset;
      test_fetch;
      test_stall;
      test_full_pop;
      test_desvio;
      test_wrap;
      test_mem_livre;
      test_reset_mid;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
